// File: rtl/cmd_responder.sv
// cmd_responder
//   Slave-side responder on the 4-bit cmd/adr/data bus. Every rising clock
//   edge is a transaction (no handshake). Commands are decoded against a
//   2**AW-entry register file; reads answer one cycle later on a registered
//   response port, CLR starts a 2**AW-cycle clear walk during which all
//   non-NOP commands are dropped and counted.
//
//   Ports
//     clk       in   sole clock, rising edge
//     rst       in   synchronous active-high reset
//     cmd       in   0 NOP, 1 WR, 2 RD, 3 INC, 4 CLR, 5..15 illegal
//     adr       in   register address
//     data      in   write / increment operand
//     busy      out  clear sequence in progress
//     rsp_valid out  one-cycle pulse, read response valid
//     rsp_adr   out  address of the read being answered
//     rsp_data  out  read data
//     ovf       out  one-cycle pulse on INC carry-out
//     err       out  one-cycle pulse on an illegal command
//     err_cnt   out  illegal commands accepted, saturating
//     drop_cnt  out  non-NOP commands dropped while busy, saturating
module cmd_responder #(
  parameter int DW = 4,
  parameter int AW = 4,
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [3:0]    cmd,
  input  logic [AW-1:0] adr,
  input  logic [DW-1:0] data,
  output logic          busy,
  output logic          rsp_valid,
  output logic [AW-1:0] rsp_adr,
  output logic [DW-1:0] rsp_data,
  output logic          ovf,
  output logic          err,
  output logic [CW-1:0] err_cnt,
  output logic [CW-1:0] drop_cnt
);

  localparam int unsigned DEPTH = 2 ** AW;

  typedef enum logic {
    S_IDLE,
    S_CLEARING
  } state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] idx_q, idx_d;
  logic [DW-1:0] mem_q [DEPTH];

  logic          rd_pend_q, rd_pend_d;
  logic [AW-1:0] rd_adr_q, rd_adr_d;
  logic          rsp_valid_q, rsp_valid_d;
  logic [AW-1:0] rsp_adr_q, rsp_adr_d;
  logic [DW-1:0] rsp_data_q, rsp_data_d;
  logic          ovf_q, ovf_d;
  logic          err_q, err_d;
  logic [CW-1:0] err_cnt_q, err_cnt_d;
  logic [CW-1:0] drop_cnt_q, drop_cnt_d;

  // Single register-file write port shared by decode and the clear walk;
  // the two never coincide because decode only runs in S_IDLE.
  logic          we;
  logic [AW-1:0] wa;
  logic [DW-1:0] wd;
  logic [DW:0]   inc_sum;

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    rd_pend_d   = 1'b0;
    rd_adr_d    = rd_adr_q;
    ovf_d       = 1'b0;
    err_d       = 1'b0;
    err_cnt_d   = err_cnt_q;
    drop_cnt_d  = drop_cnt_q;
    we          = 1'b0;
    wa          = adr;
    wd          = data;
    inc_sum     = {1'b0, mem_q[adr]} + {1'b0, data};

    // Response for a read captured on the previous edge; it uses register
    // contents before this edge's write, so it always completes even if a
    // clear starts or is already running.
    rsp_valid_d = rd_pend_q;
    rsp_adr_d   = rsp_adr_q;
    rsp_data_d  = rsp_data_q;
    if (rd_pend_q) begin
      rsp_adr_d  = rd_adr_q;
      rsp_data_d = mem_q[rd_adr_q];
    end

    case (state_q)
      S_IDLE: begin
        case (cmd)
          4'd1: we = 1'b1;
          4'd2: begin
            rd_pend_d = 1'b1;
            rd_adr_d  = adr;
          end
          4'd3: begin
            we    = 1'b1;
            wd    = inc_sum[DW-1:0];
            ovf_d = inc_sum[DW];
          end
          4'd4: begin
            state_d = S_CLEARING;
            idx_d   = '0;
          end
          4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'd10, 4'd11,
          4'd12, 4'd13, 4'd14, 4'd15: begin
            err_d = 1'b1;
            if (err_cnt_q != '1) err_cnt_d = err_cnt_q + CW'(1);
          end
          default: ; // NOP and unknown values
        endcase
      end
      S_CLEARING: begin
        we    = 1'b1;
        wa    = idx_q;
        wd    = '0;
        idx_d = idx_q + AW'(1);
        if (idx_q == '1) state_d = S_IDLE;
        case (cmd)
          4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8,
          4'd9, 4'd10, 4'd11, 4'd12, 4'd13, 4'd14, 4'd15: begin
            if (drop_cnt_q != '1) drop_cnt_d = drop_cnt_q + CW'(1);
          end
          default: ;
        endcase
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      mem_q       <= '{default: '0};
      rd_pend_q   <= 1'b0;
      rd_adr_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_adr_q   <= '0;
      rsp_data_q  <= '0;
      ovf_q       <= 1'b0;
      err_q       <= 1'b0;
      err_cnt_q   <= '0;
      drop_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      if (we) mem_q[wa] <= wd;
      rd_pend_q   <= rd_pend_d;
      rd_adr_q    <= rd_adr_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_adr_q   <= rsp_adr_d;
      rsp_data_q  <= rsp_data_d;
      ovf_q       <= ovf_d;
      err_q       <= err_d;
      err_cnt_q   <= err_cnt_d;
      drop_cnt_q  <= drop_cnt_d;
    end
  end

  assign busy      = (state_q == S_CLEARING);
  assign rsp_valid = rsp_valid_q;
  assign rsp_adr   = rsp_adr_q;
  assign rsp_data  = rsp_data_q;
  assign ovf       = ovf_q;
  assign err       = err_q;
  assign err_cnt   = err_cnt_q;
  assign drop_cnt  = drop_cnt_q;

endmodule

// File: tb/tb_cmd_responder.sv
// Scoreboard bench for cmd_responder: the stimulus side pushes the expected
// post-edge outputs of every edge into a queue, the negedge monitor pops and
// compares one entry per cycle.
module tb_cmd_responder;

  logic       clk;
  logic       rst;
  logic [3:0] cmd;
  logic [3:0] adr;
  logic [3:0] data;
  logic       busy;
  logic       rsp_valid;
  logic [3:0] rsp_adr;
  logic [3:0] rsp_data;
  logic       ovf;
  logic       err;
  logic [7:0] err_cnt;
  logic [7:0] drop_cnt;

  cmd_responder #(.DW(4), .AW(4), .CW(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .cmd      (cmd),
    .adr      (adr),
    .data     (data),
    .busy     (busy),
    .rsp_valid(rsp_valid),
    .rsp_adr  (rsp_adr),
    .rsp_data (rsp_data),
    .ovf      (ovf),
    .err      (err),
    .err_cnt  (err_cnt),
    .drop_cnt (drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit busy;
    bit rv;
    int ra;
    int rd;
    bit ovf;
    bit err;
    int ec;
    int dc;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;
  bit   run      = 1'b1;

  // Reference model: register file as an int array, clear modelled as a
  // count of remaining clear cycles, read response as a pending flag.
  int m_mem[16];
  int m_clr  = 0;
  int m_ec   = 0;
  int m_dc   = 0;
  bit m_pend = 1'b0;
  int m_pa   = 0;

  task automatic chk(input string name, input int act, input int expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s act=%0d exp=%0d t=%0t", name, act, expv, $time);
    end
  endtask

  task automatic model_edge(input bit r, input int c, input int a, input int d);
    exp_t e;
    int   s;
    e = '{default: 0};
    if (r) begin
      foreach (m_mem[i]) m_mem[i] = 0;
      m_clr  = 0;
      m_ec   = 0;
      m_dc   = 0;
      m_pend = 1'b0;
      exp_q.push_back(e);
      return;
    end
    if (m_pend) begin
      e.rv = 1'b1;
      e.ra = m_pa;
      e.rd = m_mem[m_pa];
    end
    m_pend = 1'b0;
    if (m_clr > 0) begin
      m_mem[16 - m_clr] = 0;
      m_clr--;
      if (c != 0 && m_dc < 255) m_dc++;
    end else if (c == 1) begin
      m_mem[a] = d;
    end else if (c == 2) begin
      m_pend = 1'b1;
      m_pa   = a;
    end else if (c == 3) begin
      s        = m_mem[a] + d;
      e.ovf    = (s > 15);
      m_mem[a] = s % 16;
    end else if (c == 4) begin
      m_clr = 16;
    end else if (c >= 5) begin
      e.err = 1'b1;
      if (m_ec < 255) m_ec++;
    end
    e.busy = (m_clr > 0);
    e.ec   = m_ec;
    e.dc   = m_dc;
    exp_q.push_back(e);
  endtask

  task automatic drive(input bit r, input int c, input int a, input int d);
    rst  = r;
    cmd  = 4'(c);
    adr  = 4'(a);
    data = 4'(d);
    @(posedge clk);
    #1;
    model_edge(r, c, a, d);
  endtask

  exp_t mon_e;
  always @(negedge clk) begin
    if (run) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL sb_underflow act=empty exp=entry t=%0t", $time);
      end else begin
        mon_e = exp_q.pop_front();
        chk("busy",      32'(busy),      32'(mon_e.busy));
        chk("rsp_valid", 32'(rsp_valid), 32'(mon_e.rv));
        if (mon_e.rv) begin
          chk("rsp_adr",  32'(rsp_adr),  mon_e.ra);
          chk("rsp_data", 32'(rsp_data), mon_e.rd);
        end
        chk("ovf",      32'(ovf),      32'(mon_e.ovf));
        chk("err",      32'(err),      32'(mon_e.err));
        chk("err_cnt",  32'(err_cnt),  mon_e.ec);
        chk("drop_cnt", 32'(drop_cnt), mon_e.dc);
      end
    end
  end

  task automatic read_all();
    for (int i = 0; i < 16; i++) drive(0, 2, i, 0);
    drive(0, 0, 0, 0);
  endtask

  initial begin
    int r;
    int c;

    // Reset
    repeat (3) drive(1, 0, 0, 0);

    // WR then RD same address
    drive(0, 1, 3, 9);
    drive(0, 2, 3, 0);
    drive(0, 0, 0, 0);

    // RD then WR same address returns old data; next RD returns new data
    drive(0, 2, 5, 0);
    drive(0, 1, 5, 7);
    drive(0, 2, 5, 0);
    drive(0, 0, 0, 0);

    // Back-to-back INC with carry on the second
    drive(0, 3, 2, 12);
    drive(0, 3, 2, 12);
    drive(0, 2, 2, 0);
    drive(0, 0, 0, 0);

    // Fill, clear, writes dropped during clear, first accepted write after
    for (int i = 0; i < 16; i++) drive(0, 1, i, 15);
    drive(0, 4, 0, 0);
    for (int i = 0; i < 16; i++) drive(0, 1, $urandom_range(0, 15), $urandom_range(1, 15));
    drive(0, 1, 6, 10);
    read_all();

    // Illegal commands until err_cnt saturates; memory untouched
    for (int i = 0; i < 300; i++) drive(0, $urandom_range(5, 15), $urandom_range(0, 15), $urandom_range(0, 15));
    read_all();

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      r = $urandom_range(0, 99);
      if (r < 15)      c = 0;
      else if (r < 35) c = 1;
      else if (r < 55) c = 2;
      else if (r < 75) c = 3;
      else if (r < 79) c = 4;
      else             c = $urandom_range(5, 15);
      drive(($urandom_range(0, 199) == 0), c, $urandom_range(0, 15), $urandom_range(0, 15));
    end
    read_all();

    // Read in flight when reset hits: response discarded
    drive(0, 1, 9, 4);
    drive(0, 2, 9, 0);
    drive(1, 0, 0, 0);
    drive(0, 0, 0, 0);

    // Reset on the 5th cycle of a clear with a read issued alongside
    for (int i = 0; i < 16; i++) drive(0, 1, i, i);
    drive(0, 4, 0, 0);
    for (int i = 0; i < 4; i++) drive(0, 3, i, 1);
    drive(1, 2, 12, 0);
    drive(0, 0, 0, 0);
    read_all();

    @(negedge clk);
    #1;
    run = 1'b0;
    chk("sb_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
